// File: rtl/pipelined_adder.sv
// pipelined_adder: segmented-carry pipelined add/sub with valid/ready handshake.
// Define ADDER_OVERFLOW_EN to add the signed overflow output.
module pipelined_adder #(
  parameter int WIDTH = 16,
  parameter int SEG = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             out_valid,
  input  logic             out_ready
`ifdef ADDER_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);
  localparam int NSTG = WIDTH / SEG;
  logic w_stall;
  assign w_stall = out_valid & ~out_ready;
  assign in_ready = ~w_stall;
  if (WIDTH % SEG != 0) begin : g_bad_param
    $error("pipelined_adder: WIDTH must be a multiple of SEG");
  end
  for (genvar s = 0; s < NSTG; s++) begin : stg
    localparam int RW = WIDTH - s * SEG;
    logic [RW-1:0] w_a;
    logic [RW-1:0] w_b;
    logic w_ci;
    logic w_vi;
    logic [SEG:0] w_add;
    logic [(s+1)*SEG-1:0] w_s;
    logic [(s+1)*SEG-1:0] r_s;
    logic r_c;
    logic r_v;
    assign w_add = {1'b0, w_a[SEG-1:0]} + {1'b0, w_b[SEG-1:0]} + {{SEG{1'b0}}, w_ci};
    if (s == 0) begin : g_in
      assign w_a = a;
      assign w_b = b ^ {WIDTH{sub}};
      assign w_ci = sub;
      assign w_vi = in_valid;
      assign w_s = w_add[SEG-1:0];
    end else begin : g_in
      // operands arrive already skewed; lower result segments ride along for deskew
      assign w_a = stg[s-1].g_skw.r_a;
      assign w_b = stg[s-1].g_skw.r_b;
      assign w_ci = stg[s-1].r_c;
      assign w_vi = stg[s-1].r_v;
      assign w_s = {w_add[SEG-1:0], stg[s-1].r_s};
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_s <= '0;
      end else if (!w_stall) begin
        r_v <= w_vi;
        if (w_vi) begin
          r_c <= w_add[SEG];
          r_s <= w_s;
        end
      end
    end
    if (s < NSTG - 1) begin : g_skw
      logic [RW-SEG-1:0] r_a;
      logic [RW-SEG-1:0] r_b;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (!w_stall && w_vi) begin
          r_a <= w_a[RW-1:SEG];
          r_b <= w_b[RW-1:SEG];
        end
      end
    end
`ifdef ADDER_OVERFLOW_EN
    if (s == NSTG - 1) begin : g_ovf
      logic r_o;
      // carry into the MSB is recovered from the MSB sum bit and its operand bits
      always_ff @(posedge clk) begin
        if (rst) r_o <= 1'b0;
        else if (!w_stall && w_vi) r_o <= w_a[SEG-1] ^ w_b[SEG-1] ^ w_add[SEG-1] ^ w_add[SEG];
      end
    end
`endif
  end
  assign sum = stg[NSTG-1].r_s;
  assign carry = stg[NSTG-1].r_c;
  assign out_valid = stg[NSTG-1].r_v;
`ifdef ADDER_OVERFLOW_EN
  assign overflow = stg[NSTG-1].g_ovf.r_o;
`endif
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed vectors on SEG=4 and SEG=16 instances plus streaming/reset sequences.
module tb_pipelined_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic sub = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic ir4, ov4, c4, ir1, ov1, c1;
  logic [15:0] s4, s1;
`ifdef ADDER_OVERFLOW_EN
  logic of4, of1;
`endif
  int n_cmp = 0;
  int n_bad = 0;

  pipelined_adder #(.WIDTH(16), .SEG(4)) dut4 (
    .clk(clk), .rst(rst), .a(a), .b(b), .sub(sub), .in_valid(in_valid), .in_ready(ir4),
    .sum(s4), .carry(c4), .out_valid(ov4), .out_ready(out_ready)
`ifdef ADDER_OVERFLOW_EN
    , .overflow(of4)
`endif
  );
  pipelined_adder #(.WIDTH(16), .SEG(16)) dut1 (
    .clk(clk), .rst(rst), .a(a), .b(b), .sub(sub), .in_valid(in_valid), .in_ready(ir1),
    .sum(s1), .carry(c1), .out_valid(ov1), .out_ready(out_ready)
`ifdef ADDER_OVERFLOW_EN
    , .overflow(of1)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic sub;
    logic [15:0] s;
    logic c;
    logic o;
  } vec_t;

  vec_t v[10];
  logic [16:0] q[$];
  logic [16:0] held, expv;
  logic have, stall_prev, acc_in;
  int got, sent, cyc;

  initial begin
    v[0] = '{16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0};
    v[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    v[2] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    v[3] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    v[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    v[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    v[6] = '{16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    v[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    v[8] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};
    v[9] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};

    tick();
    tick();
    rst = 1'b0;
    chk("reset out_valid", 32'(ov4), 32'd0);
    chk("reset sum/carry", {15'd0, c4, s4}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle out_valid", 32'(ov4), 32'd0);
      chk("idle in_ready", 32'(ir4), 32'd1);
    end
    chk("idle sum/carry", {15'd0, c4, s4}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      a = v[i].a;
      b = v[i].b;
      sub = v[i].sub;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk($sformatf("seg16 valid v%0d", i), 32'(ov1), 32'd1);
      chk($sformatf("seg16 result v%0d", i), {15'd0, c1, s1}, {15'd0, v[i].c, v[i].s});
`ifdef ADDER_OVERFLOW_EN
      chk($sformatf("seg16 ovf v%0d", i), 32'(of1), 32'(v[i].o));
`endif
      tick();
      tick();
      chk($sformatf("seg4 early valid v%0d", i), 32'(ov4), 32'd0);
      tick();
      chk($sformatf("seg4 valid v%0d", i), 32'(ov4), 32'd1);
      chk($sformatf("seg4 result v%0d", i), {15'd0, c4, s4}, {15'd0, v[i].c, v[i].s});
`ifdef ADDER_OVERFLOW_EN
      chk($sformatf("seg4 ovf v%0d", i), 32'(of4), 32'(v[i].o));
`endif
      tick();
      chk($sformatf("seg4 drained v%0d", i), 32'(ov4), 32'd0);
    end

    got = 0;
    sent = 0;
    cyc = 0;
    have = 1'b0;
    stall_prev = 1'b0;
    held = '0;
    while (got < 8 && cyc < 60) begin
      if (!have && sent < 8) begin
        a = 16'($urandom);
        b = 16'($urandom);
        sub = 1'($urandom_range(0, 1));
        have = 1'b1;
      end
      in_valid = have;
      out_ready = !(cyc >= 5 && cyc <= 7);
      #1;
      if (stall_prev) chk("stall hold", {15'd0, c4, s4}, {15'd0, held});
      stall_prev = ov4 && !out_ready;
      if (stall_prev) begin
        held = {c4, s4};
        chk("stall in_ready", 32'(ir4), 32'd0);
      end
      acc_in = in_valid && ir4;
      if (ov4 && out_ready) begin
        if (q.size() == 0) chk("spurious output", 32'(ov4), 32'd0);
        else begin
          expv = q.pop_front();
          chk($sformatf("stream result %0d", got), {15'd0, c4, s4}, {15'd0, expv});
        end
        got++;
      end
      if (acc_in) begin
        q.push_back({1'b0, a} + {1'b0, b ^ {16{sub}}} + 17'(sub));
        have = 1'b0;
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream count", 32'(got), 32'd8);
    chk("stream leftover", 32'(q.size()), 32'd0);
    repeat (6) tick();

    for (int i = 0; i < 3; i++) begin
      a = 16'h1111 * 16'(i + 1);
      b = 16'h0101;
      sub = 1'b0;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("pre-reset out_valid", 32'(ov4), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("post-reset out_valid seg4", 32'(ov4), 32'd0);
    chk("post-reset out_valid seg16", 32'(ov1), 32'd0);
    chk("post-reset in_ready", 32'(ir4), 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("flushed result absent", 32'(ov4), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the team's 1-bit half adder.
- Adds or subtracts two WIDTH-bit operands by splitting the carry chain into SEG-bit segments, with one register stage per segment.
- Throughput is one result per clock.
- Uses a valid/ready handshake so it can sit between streaming producer and consumer blocks in the datapath.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of SEG.
- SEG, 4, bits resolved per pipeline stage; NSTG = WIDTH/SEG stages.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- sub  input  1  0: a+b; 1: a-b.
- in_valid  input  1  a/b/sub are valid this cycle.
- in_ready  output  1  block accepts input this cycle.
- sum  output  WIDTH  result, mod 2^WIDTH.
- carry  output  1  carry out of MSB. For sub=1 this is the inverted borrow: 1 means a>=b unsigned.
- out_valid  output  1  sum/carry valid.
- out_ready  input  1  consumer accepts output.
- overflow  output  1  signed overflow; exists only with ADDER_OVERFLOW_EN.

Behaviour:
- Reset (rst=1 at a clk edge):
  - all stage valid bits, out_valid, sum, carry (and overflow) clear to 0.
  - in_ready reads 1 in the cycle after reset.
  - Reset mid-operation discards all in-flight results; no partial output appears.
- Transfer rules:
  - Input transfer occurs on a clk edge with in_valid & in_ready.
  - Output transfer occurs on a clk edge with out_valid & out_ready.
- Stall:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall, combinational.
  - While stalled, every pipeline register, including skew registers and partial sums, holds its value.
  - sum/carry/out_valid stay stable until accepted.
- Subtraction: operand B is effectively ~b, and the stage-0 carry-in equals sub.
- Stage k (0..NSTG-1):
  - adds segment k of a and (b^{WIDTH{sub}}) plus the carry registered from stage k-1.
  - registers the SEG-bit result and the carry out.
- Operand skew: upper segments of a/b are delayed through input skew registers so each segment meets its carry in the correct cycle.
- Sum deskew: lower result segments are delayed through output registers so all segments of a result emerge together.
- Latency:
  - exactly NSTG cycles from input transfer to out_valid=1, with no stall.
  - SEG=WIDTH gives a 1-cycle registered adder.
- Throughput: back-to-back inputs with out_ready=1 yield back-to-back outputs, one per cycle, in order.
- Bubbles: in_valid=0 cycles propagate as valid=0 through the pipeline and are not collapsed.
- Wrap-around: sum is mod 2^WIDTH and carry captures bit WIDTH.
  - Example: all-ones + 1 gives sum=0, carry=1.
- Simultaneous accept and new input while out_valid=1 & out_ready=1: no stall, so the pipeline advances and accepts the new input in the same cycle.
- Bad parameters: WIDTH % SEG != 0 is a configuration error; elaboration must fail (generate-time check).

Optional Feature:
- Macro: ADDER_OVERFLOW_EN.
- Defined:
  - port overflow is present.
  - overflow = carry-into-MSB XOR carry-out-of-MSB, computed in the final stage and aligned with sum.
  - overflow resets to 0 and holds during stall.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, release, in_valid=0 for 10 cycles -> out_valid, sum, carry stay 0; in_ready=1.
2. Single add, WIDTH=16, SEG=4: a=0x1234, b=0x0FCD, sub=0 -> exactly 4 cycles later out_valid=1, sum=0x2201, carry=0.
3. Carry ripple across all segments: a=0xFFFF, b=0x0001, sub=0 -> sum=0x0000, carry=1. With ADDER_OVERFLOW_EN: overflow=0.
4. Subtract and borrow:
   - a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, carry=0.
   - a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, carry=1; overflow=1 when ADDER_OVERFLOW_EN.
5. Streaming with backpressure: 8 back-to-back random inputs; out_ready low for cycles 5-7 -> in_ready low during stall, no result lost or duplicated, output order matches a scoreboard, output held stable while stalled.
6. Reset mid-stream: 3 inputs in flight, assert rst one cycle -> out_valid=0 next cycle and none of the 3 results ever appear. Repeat scenarios 2 and 3 with SEG=16 -> latency 1 cycle.
